spiflash_sync_model: RTL and testbench
======================================

Name: spiflash_sync_model

Overview:
Synthesizable, single-clock SPI/QPI flash slave for FPGA-hosted demo and hardware-in-the-loop runs of the accelerator boot path. It oversamples flash_clk/flash_csb/IO on the system clock and decodes a parametrised command subset. Read data comes from an internal byte array that the host preloads through a side port. It replaces the behavioural flash model where real hardware needs a flash stand-in, and adds 1-1-1 reads, configurable dummy cycles, QE enforcement and address wrap.

Parameters:
ADDR_BITS, 16, byte-address width of the backing array (depth 2^ADDR_BITS); 24-bit SPI addresses are truncated to this.
SYNC_STAGES, 2, synchroniser depth on flash_clk, flash_csb, flash_io_in.
DUMMY_CLKS, 4, dummy SCK cycles after the mode byte for EB.
FAST_DUMMY_CLKS, 8, dummy SCK cycles for 0B.

Ports:
clock  in  1  system clock; must run at least 4x the flash_clk frequency
reset  in  1  synchronous, active-high reset
flash_clk  in  1  SPI clock from master (async)
flash_csb  in  1  chip select, active low (async)
flash_io_in  in  4  IO[3:0] input samples
flash_io_out  out  4  IO[3:0] drive values
flash_io_oe  out  4  per-line output enable
load_we  in  1  preload write strobe
load_addr  in  ADDR_BITS  preload byte address
load_data  in  8  preload byte
qpi_active  out  1  QPI mode flag
sr2_qe  out  1  quad-enable bit
err_unimpl  out  1  sticky unimplemented/illegal-command flag

Behaviour:
- Reset: flash_io_out=0, flash_io_oe=0, qpi_active=0, sr2_qe=0, err_unimpl=0, crm=0, FSM IDLE, bit counter 0. Array contents are not cleared.
- Edges are detected on synchronised signals. An SCK rise samples input; an SCK fall shifts output. Outputs change within SYNC_STAGES+2 clocks of the pin edge.
- CSB rise, from any state, forces OE=0 and sends the FSM to IDLE on the next clock. A partially shifted byte is discarded.
- CSB fall starts in CMD state, or in ADDR state for EB when crm=1. crm is cleared at every CSB fall, then reset to 1 only by a fresh A5 mode byte.
- Bit width per SCK:
  - QPI: 4 bits for all phases.
  - SPI: 1 bit for command; 4 bits for EB address/mode/data; 1 bit for 03/0B.
  - Byte complete at 8 bits, MSB first; IO3 carries the MSB nibble bit.
- Commands:
  - 03 Read (SPI only): ADDR(3 bytes) then DATA on IO1.
  - 0B Fast read: ADDR(3), FAST_DUMMY_CLKS, then DATA. In SPI, data on IO1; in QPI, data on all 4 lines.
  - EB Quad I/O read: ADDR(3), MODE(1), DUMMY_CLKS, then DATA on all 4 lines.
    - Mode byte A5 sets crm; any other value clears it.
    - In SPI mode with sr2_qe=0: err_unimpl=1, FSM goes to IGNORE until CSB rises.
  - 31 Write SR2: the next byte's bit1 goes to sr2_qe.
  - 38 Enter QPI: sets qpi_active, then IGNORE.
  - FF: clears qpi_active and crm, then IGNORE.
  - 50: no-op, then IGNORE.
  - Other opcodes (including 03 in QPI): err_unimpl=1, then IGNORE.
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, WRSR2, IGNORE.
- DATA phase:
  - The byte at addr is fetched before the first data SCK fall; the array has 1-clock read latency.
  - addr increments by one per byte, wrapping from 2^ADDR_BITS-1 to 0.
  - OE asserts on the first data SCK fall: IO1 only for 1-bit reads, 4'b1111 otherwise. OE stays high until CSB rises.
- Reset-recovery sequence: CSB low and io_in[0]=1 for 8 consecutive SCK rises while in CMD state (SPI or QPI) behaves as FF.
- Preload: load_we writes load_data into array[load_addr] on the clock edge. Preload takes priority over a coincident read fetch; a host read of the same address returns the new data.
- err_unimpl clears only on reset.
- If reset and a CSB fall or SCK edge land on the same clock, reset wins.

Test Plan:
- Preload 0x0100..0x0103 = 11 22 33 44; SPI 03 at 0x000100, 32 data clocks -> IO1 returns 11 22 33 44, flash_io_oe=4'b0010 only during data.
- Send 31 with 0x02, then EB addr 0x000100, mode A5, DUMMY_CLKS=4 -> quad data 11 22. On the next CSB, send only addr 0x000102 + mode FF -> 33 44, crm=0.
- EB in SPI mode with sr2_qe=0 -> err_unimpl=1, OE stays 0 for the whole transaction.
- ADDR_BITS=16, preload 0xFFFF=AA and 0x0000=BB; 0B read at 0x00FFFF -> AA then BB (wrap).
- Send 38 -> qpi_active=1; QPI 0B at 0x000100 with 8 dummy clocks -> 4-bit 11 22; then FF -> qpi_active=0. Send opcode 9F -> err_unimpl=1.
- Assert reset mid-DATA -> next clock flash_io_oe=0, FSM IDLE, qpi_active=0; array contents retained on the next read.

Source files
------------

// File: rtl/spiflash_sync_model.sv
// SPI/QPI flash stand-in for FPGA boot-path runs: oversamples the flash pins on the system clock
// and serves 03/0B/EB reads out of a host-preloaded byte array.
`timescale 1ns/1ps
module spiflash_sync_model #(
    parameter int ADDR_BITS       = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DUMMY_CLKS      = 4,
    parameter int FAST_DUMMY_CLKS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flash_clk,
    input  logic                 flash_csb,
    input  logic [3:0]           flash_io_in,
    output logic [3:0]           flash_io_out,
    output logic [3:0]           flash_io_oe,
    input  logic                 load_we,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [7:0]           load_data,
    output logic                 qpi_active,
    output logic                 sr2_qe,
    output logic                 err_unimpl
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, WRSR2, IGNORE} state_t;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FAST  = 8'h0B;
    localparam logic [7:0] OP_QUAD  = 8'hEB;
    localparam logic [7:0] OP_WRSR2 = 8'h31;
    localparam logic [7:0] OP_QPI   = 8'h38;
    localparam logic [7:0] OP_RST   = 8'hFF;
    localparam logic [7:0] OP_NOP   = 8'h50;
    localparam logic [7:0] MODE_CRM = 8'hA5;
    localparam logic [7:0] QUAD_DUMMY_LAST = 8'(DUMMY_CLKS - 1);
    localparam logic [7:0] FAST_DUMMY_LAST = 8'(FAST_DUMMY_CLKS - 1);

    logic [SYNC_STAGES-1:0] clk_pipe, csb_pipe;
    logic [3:0]             io_pipe [SYNC_STAGES];
    logic                   clk_prev, csb_prev;

    // NOTE: the synchronisers and the byte array carry no reset; the pin pipeline must keep
    // tracking a low CSB through reset so no false CSB fall appears afterwards, and the
    // preloaded image has to survive a reset.
    always_ff @(posedge clock) begin
        clk_pipe[0] <= flash_clk;
        csb_pipe[0] <= flash_csb;
        io_pipe[0]  <= flash_io_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            clk_pipe[i] <= clk_pipe[i-1];
            csb_pipe[i] <= csb_pipe[i-1];
            io_pipe[i]  <= io_pipe[i-1];
        end
        clk_prev <= clk_pipe[SYNC_STAGES-1];
        csb_prev <= csb_pipe[SYNC_STAGES-1];
    end

    logic       clk_s, csb_s;
    logic [3:0] io_s;
    logic       sck_rise, sck_fall, csb_rise, csb_fall;

    assign clk_s    = clk_pipe[SYNC_STAGES-1];
    assign csb_s    = csb_pipe[SYNC_STAGES-1];
    assign io_s     = io_pipe[SYNC_STAGES-1];
    assign sck_rise = clk_s & ~clk_prev & ~csb_s;
    assign sck_fall = ~clk_s & clk_prev & ~csb_s;
    assign csb_rise = csb_s & ~csb_prev;
    assign csb_fall = ~csb_s & csb_prev;

    state_t                 state;
    logic [7:0]             cmd;
    logic [6:0]             shift;
    logic [3:0]             bit_cnt;
    logic [1:0]             addr_cnt;
    logic [ADDR_BITS-1:0]   addr;
    logic [7:0]             dummy_cnt;
    logic [7:0]             out_shift;
    logic [2:0]             out_cnt;
    logic                   crm;
    logic [3:0]             rec_cnt;
    logic                   rec_alive;
    logic                   pend_err;

    logic [7:0] mem [2**ADDR_BITS];
    logic [7:0] rd_data;

    // Write-first: a preload to the address being fetched is what the fetch returns.
    always_ff @(posedge clock) begin
        if (load_we) mem[load_addr] <= load_data;
        rd_data <= (load_we && load_addr == addr) ? load_data : mem[addr];
    end

    logic       in_wide, out_wide, byte_done;
    logic [3:0] bit_next;
    logic [7:0] byte_next, out_byte, dummy_last;

    assign in_wide    = qpi_active || (cmd == OP_QUAD && state != CMD);
    assign out_wide   = qpi_active || cmd == OP_QUAD;
    assign bit_next   = bit_cnt + (in_wide ? 4'd4 : 4'd1);
    assign byte_done  = (bit_next == 4'd8);
    assign byte_next  = in_wide ? {shift[3:0], io_s} : {shift, io_s[0]};
    assign out_byte   = (out_cnt == 3'd0) ? rd_data : out_shift;
    assign dummy_last = (cmd == OP_QUAD) ? QUAD_DUMMY_LAST : FAST_DUMMY_LAST;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cmd          <= 8'h00;
            shift        <= '0;
            bit_cnt      <= '0;
            addr_cnt     <= '0;
            addr         <= '0;
            dummy_cnt    <= '0;
            out_shift    <= '0;
            out_cnt      <= '0;
            crm          <= 1'b0;
            rec_cnt      <= '0;
            rec_alive    <= 1'b0;
            pend_err     <= 1'b0;
            flash_io_out <= '0;
            flash_io_oe  <= '0;
            qpi_active   <= 1'b0;
            sr2_qe       <= 1'b0;
            err_unimpl   <= 1'b0;
        end else if (csb_rise) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            flash_io_oe  <= '0;
            flash_io_out <= '0;
            if (pend_err) begin
                err_unimpl <= 1'b1;
                pend_err   <= 1'b0;
            end
        end else if (csb_fall) begin
            crm       <= 1'b0;
            bit_cnt   <= '0;
            addr_cnt  <= '0;
            out_cnt   <= '0;
            rec_cnt   <= '0;
            pend_err  <= 1'b0;
            rec_alive <= ~crm;
            if (crm) begin
                state <= ADDR;
                cmd   <= OP_QUAD;
            end else begin
                state <= CMD;
            end
        end else if (sck_rise) begin
            if (state inside {CMD, ADDR, MODE, WRSR2}) begin
                shift   <= byte_next[6:0];
                bit_cnt <= byte_done ? 4'd0 : bit_next;
            end
            // Reset-recovery run: IO0 held high on every SCK rise since CSB fell.
            if (state == CMD || (state == IGNORE && pend_err)) begin
                if (!io_s[0]) begin
                    rec_alive <= 1'b0;
                    if (pend_err) begin
                        err_unimpl <= 1'b1;
                        pend_err   <= 1'b0;
                    end
                end else if (rec_alive) begin
                    rec_cnt <= rec_cnt + 4'd1;
                end
            end
            case (state)
                CMD: if (byte_done) begin
                    cmd <= byte_next;
                    case (byte_next)
                        OP_READ: if (qpi_active) begin
                            err_unimpl <= 1'b1;
                            state      <= IGNORE;
                        end else begin
                            state <= ADDR;
                        end
                        OP_FAST: state <= ADDR;
                        OP_QUAD: if (!qpi_active && !sr2_qe) begin
                            err_unimpl <= 1'b1;
                            state      <= IGNORE;
                        end else begin
                            state <= ADDR;
                        end
                        OP_WRSR2: state <= WRSR2;
                        OP_QPI: begin
                            qpi_active <= 1'b1;
                            state      <= IGNORE;
                        end
                        OP_RST: begin
                            qpi_active <= 1'b0;
                            crm        <= 1'b0;
                            state      <= IGNORE;
                        end
                        OP_NOP: state <= IGNORE;
                        default: begin
                            // A QPI byte that may still become a recovery run holds its error back.
                            if (qpi_active && rec_alive && io_s[0]) pend_err   <= 1'b1;
                            else                                   err_unimpl <= 1'b1;
                            state <= IGNORE;
                        end
                    endcase
                end
                ADDR: if (byte_done) begin
                    addr     <= ADDR_BITS'({addr, byte_next});
                    addr_cnt <= addr_cnt + 2'd1;
                    if (addr_cnt == 2'd2) begin
                        dummy_cnt <= '0;
                        out_cnt   <= '0;
                        if (cmd == OP_QUAD)                               state <= MODE;
                        else if (cmd == OP_FAST && FAST_DUMMY_CLKS != 0)  state <= DUMMY;
                        else                                              state <= DATA;
                    end
                end
                MODE: if (byte_done) begin
                    crm       <= (byte_next == MODE_CRM);
                    dummy_cnt <= '0;
                    out_cnt   <= '0;
                    state     <= (DUMMY_CLKS != 0) ? DUMMY : DATA;
                end
                DUMMY: begin
                    if (dummy_cnt == dummy_last) state <= DATA;
                    else                         dummy_cnt <= dummy_cnt + 8'd1;
                end
                WRSR2: if (byte_done) begin
                    sr2_qe <= byte_next[1];
                    state  <= IGNORE;
                end
                IGNORE: if (pend_err && rec_alive && io_s[0] && rec_cnt == 4'd7) begin
                    qpi_active <= 1'b0;
                    crm        <= 1'b0;
                    pend_err   <= 1'b0;
                    rec_alive  <= 1'b0;
                end
                default: ;
            endcase
        end else if (sck_fall && state == DATA) begin
            flash_io_oe <= out_wide ? 4'b1111 : 4'b0010;
            out_cnt     <= out_cnt + (out_wide ? 3'd4 : 3'd1);
            if (out_cnt == 3'd0) addr <= addr + 1'b1;
            if (out_wide) begin
                flash_io_out <= out_byte[7:4];
                out_shift    <= {out_byte[3:0], 4'h0};
            end else begin
                flash_io_out <= {2'b00, out_byte[7], 1'b0};
                out_shift    <= {out_byte[6:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_spiflash_sync_model.sv
// Self-checking bench for spiflash_sync_model: bit-banged SPI/QPI master, table of reads plus
// hand-written sequences for EB continuation, QPI, error and reset corners.
`timescale 1ns/1ps
module tb_spiflash_sync_model;
    localparam int ADDR_BITS = 16;
    localparam int HALF      = 80;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 flash_clk = 1'b0;
    logic                 flash_csb = 1'b1;
    logic [3:0]           flash_io_in = 4'h0;
    logic [3:0]           flash_io_out;
    logic [3:0]           flash_io_oe;
    logic                 load_we = 1'b0;
    logic [ADDR_BITS-1:0] load_addr = '0;
    logic [7:0]           load_data = 8'h00;
    logic                 qpi_active, sr2_qe, err_unimpl;

    always #5 clock = ~clock;

    spiflash_sync_model #(
        .ADDR_BITS(ADDR_BITS), .SYNC_STAGES(2), .DUMMY_CLKS(4), .FAST_DUMMY_CLKS(8)
    ) dut (
        .clock(clock), .reset(reset), .flash_clk(flash_clk), .flash_csb(flash_csb),
        .flash_io_in(flash_io_in), .flash_io_out(flash_io_out), .flash_io_oe(flash_io_oe),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .qpi_active(qpi_active), .sr2_qe(sr2_qe), .err_unimpl(err_unimpl)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          nbytes;
        logic [31:0] exp_bytes;
        logic [3:0]  exp_oe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic preload(input logic [ADDR_BITS-1:0] a, input logic [7:0] d);
        @(negedge clock);
        load_we = 1'b1; load_addr = a; load_data = d;
        @(negedge clock);
        load_we = 1'b0;
    endtask

    // One SCK period; outputs are sampled just before the rising edge.
    task automatic sck_cycle(input logic [3:0] io, output logic [3:0] seen_io, output logic [3:0] seen_oe);
        flash_io_in = io;
        #(HALF);
        seen_io = flash_io_out;
        seen_oe = flash_io_oe;
        flash_clk = 1'b1;
        #(HALF);
        flash_clk = 1'b0;
    endtask

    task automatic csb_low();
        flash_csb = 1'b0;
        #(HALF);
    endtask

    task automatic csb_high();
        #(HALF);
        flash_csb = 1'b1;
        flash_io_in = 4'h0;
        #(2*HALF);
    endtask

    task automatic send_spi(input logic [7:0] b);
        logic [3:0] s_io, s_oe;
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]}, s_io, s_oe);
    endtask

    task automatic send_quad(input logic [7:0] b);
        logic [3:0] s_io, s_oe;
        sck_cycle(b[7:4], s_io, s_oe);
        sck_cycle(b[3:0], s_io, s_oe);
    endtask

    task automatic send_addr(input logic wide, input logic [23:0] a);
        for (int b = 2; b >= 0; b--) begin
            if (wide) send_quad(a[8*b +: 8]);
            else      send_spi(a[8*b +: 8]);
        end
    endtask

    task automatic dummy(input int n);
        logic [3:0] s_io, s_oe;
        for (int i = 0; i < n; i++) sck_cycle(4'h0, s_io, s_oe);
    endtask

    task automatic read_byte(input logic wide, output logic [7:0] b, output logic [3:0] oe);
        logic [3:0] s_io;
        b = 8'h00;
        if (wide) begin
            sck_cycle(4'h0, s_io, oe); b[7:4] = s_io;
            sck_cycle(4'h0, s_io, oe); b[3:0] = s_io;
        end else begin
            for (int i = 0; i < 8; i++) begin
                sck_cycle(4'h0, s_io, oe);
                b = {b[6:0], s_io[1]};
            end
        end
    endtask

    task automatic read_and_score(input logic wide, input int n, input logic [3:0] exp_oe, input string tag);
        logic [7:0] got, exp;
        logic [3:0] oe_seen;
        oe_seen = 4'h0;
        for (int k = 0; k < n; k++) begin
            read_byte(wide, got, oe_seen);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            check($sformatf("%s byte%0d", tag, k), 32'(got), 32'(exp));
        end
        check({tag, " oe"}, 32'(oe_seen), 32'(exp_oe));
    endtask

    task automatic push_expected(input int n, input logic [31:0] bytes);
        for (int k = 0; k < n; k++) exp_q.push_back(bytes[8*(n-1-k) +: 8]);
    endtask

    task automatic run_read(input vec_t v, input logic qpi, input string tag);
        push_expected(v.nbytes, v.exp_bytes);
        csb_low();
        if (qpi) send_quad(v.op);
        else     send_spi(v.op);
        check({tag, " oe before data"}, 32'(flash_io_oe), 32'h0);
        send_addr(qpi, v.addr);
        if (v.op == 8'h0B) dummy(8);
        read_and_score(qpi, v.nbytes, v.exp_oe, tag);
        csb_high();
        check({tag, " oe released"}, 32'(flash_io_oe), 32'h0);
    endtask

    vec_t       spi_vecs [4];
    vec_t       v;
    logic [3:0] s_io, s_oe, oe_acc;

    initial begin
        spi_vecs[0] = '{op: 8'h03, addr: 24'h000100, nbytes: 4, exp_bytes: 32'h11223344, exp_oe: 4'b0010};
        spi_vecs[1] = '{op: 8'h0B, addr: 24'h00FFFF, nbytes: 2, exp_bytes: 32'h0000AABB, exp_oe: 4'b0010};
        spi_vecs[2] = '{op: 8'h03, addr: 24'h000102, nbytes: 2, exp_bytes: 32'h00003344, exp_oe: 4'b0010};
        spi_vecs[3] = '{op: 8'h0B, addr: 24'h000101, nbytes: 3, exp_bytes: 32'h00223344, exp_oe: 4'b0010};

        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset io_out", 32'(flash_io_out), 32'h0);
        check("reset io_oe", 32'(flash_io_oe), 32'h0);
        check("reset qpi_active", 32'(qpi_active), 32'h0);
        check("reset sr2_qe", 32'(sr2_qe), 32'h0);
        check("reset err_unimpl", 32'(err_unimpl), 32'h0);

        preload(16'h0100, 8'h11);
        preload(16'h0101, 8'h22);
        preload(16'h0102, 8'h33);
        preload(16'h0103, 8'h44);
        preload(16'hFFFF, 8'hAA);
        preload(16'h0000, 8'hBB);

        for (int i = 0; i < 4; i++) run_read(spi_vecs[i], 1'b0, $sformatf("spi vec%0d", i));

        // Quad enable, then EB with continuous-read mode and a command-less follow-up.
        csb_low(); send_spi(8'h31); send_spi(8'h02); csb_high();
        check("sr2_qe set", 32'(sr2_qe), 32'h1);
        push_expected(2, 32'h1122);
        csb_low(); send_spi(8'hEB); send_addr(1'b1, 24'h000100); send_quad(8'hA5); dummy(4);
        read_and_score(1'b1, 2, 4'b1111, "eb a5");
        csb_high();
        push_expected(2, 32'h3344);
        csb_low(); send_addr(1'b1, 24'h000102); send_quad(8'hFF); dummy(4);
        read_and_score(1'b1, 2, 4'b1111, "eb crm");
        csb_high();
        v = '{op: 8'h03, addr: 24'h000103, nbytes: 1, exp_bytes: 32'h44, exp_oe: 4'b0010};
        run_read(v, 1'b0, "after crm clear");

        // QPI entry, 4-bit fast read, FF exit, then re-entry and IO0 recovery run.
        csb_low(); send_spi(8'h38); csb_high();
        check("qpi entered", 32'(qpi_active), 32'h1);
        v = '{op: 8'h0B, addr: 24'h000100, nbytes: 2, exp_bytes: 32'h1122, exp_oe: 4'b1111};
        run_read(v, 1'b1, "qpi 0B");
        csb_low(); send_quad(8'hFF); csb_high();
        check("qpi exit FF", 32'(qpi_active), 32'h0);
        csb_low(); send_spi(8'h38); csb_high();
        check("qpi re-entered", 32'(qpi_active), 32'h1);
        csb_low();
        for (int i = 0; i < 8; i++) sck_cycle(4'b0001, s_io, s_oe);
        csb_high();
        check("recovery qpi", 32'(qpi_active), 32'h0);
        check("recovery no err", 32'(err_unimpl), 32'h0);

        // EB in SPI without quad enable is rejected and never drives the bus.
        csb_low(); send_spi(8'h31); send_spi(8'h00); csb_high();
        check("sr2_qe cleared", 32'(sr2_qe), 32'h0);
        oe_acc = 4'h0;
        csb_low(); send_spi(8'hEB);
        for (int i = 0; i < 16; i++) begin
            sck_cycle(4'h5, s_io, s_oe);
            oe_acc |= s_oe;
        end
        csb_high();
        check("eb noqe err", 32'(err_unimpl), 32'h1);
        check("eb noqe oe", 32'(oe_acc), 32'h0);

        // Reset in the middle of a QPI data phase.
        csb_low(); send_spi(8'h38); csb_high();
        push_expected(1, 32'h11);
        csb_low(); send_quad(8'h0B); send_addr(1'b1, 24'h000100); dummy(8);
        read_and_score(1'b1, 1, 4'b1111, "pre reset");
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid reset oe", 32'(flash_io_oe), 32'h0);
        check("mid reset qpi", 32'(qpi_active), 32'h0);
        check("mid reset err", 32'(err_unimpl), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        csb_high();
        v = '{op: 8'h03, addr: 24'h00FFFF, nbytes: 2, exp_bytes: 32'hAABB, exp_oe: 4'b0010};
        run_read(v, 1'b0, "retained wrap");

        csb_low(); send_spi(8'h9F); csb_high();
        check("9F err", 32'(err_unimpl), 32'h1);
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
